// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter with registered grant, locked ownership and bus timeout.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break from IDLE; fixed priority otherwise).
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                m_cyc,
  input  logic [1:0]                m_stb,
  input  logic [1:0]                m_we,
  input  logic [2*ADDR_WIDTH-1:0]   m_adr,
  input  logic [2*DATA_WIDTH/8-1:0] m_sel,
  input  logic [2*DATA_WIDTH-1:0]   m_dat_w,
  output logic [DATA_WIDTH-1:0]     m_dat_r,
  output logic [1:0]                m_ack,
  output logic [1:0]                m_err,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [ADDR_WIDTH-1:0]     s_adr,
  output logic [DATA_WIDTH/8-1:0]   s_sel,
  output logic [DATA_WIDTH-1:0]     s_dat_w,
  input  logic [DATA_WIDTH-1:0]     s_dat_r,
  input  logic                      s_ack,
  input  logic                      s_err,
  output logic [1:0]                grant
);

  localparam int SW       = DATA_WIDTH / 8;
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          active;
  logic          own;
  logic          stall;
  logic          tmo;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc[0] && m_cyc[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_q ? ST_OWN0 : ST_OWN1;
`else
          state_d = ST_OWN0;
`endif
        end else if (m_cyc[0]) begin
          state_d = ST_OWN0;
        end else if (m_cyc[1]) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: if (!m_cyc[0]) state_d = m_cyc[1] ? ST_OWN1 : ST_IDLE;
      ST_OWN1: if (!m_cyc[1]) state_d = m_cyc[0] ? ST_OWN0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (state_d == ST_OWN0 && state_q != ST_OWN0) last_d = 1'b0;
    if (state_d == ST_OWN1 && state_q != ST_OWN1) last_d = 1'b1;
  end
`endif

  always_comb begin
    active  = (state_q != ST_IDLE);
    own     = (state_q == ST_OWN1);
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    if (active) begin
      s_cyc   = m_cyc[own];
      s_stb   = m_stb[own];
      s_we    = m_we[own];
      s_adr   = m_adr[int'(own)*ADDR_WIDTH +: ADDR_WIDTH];
      s_sel   = m_sel[int'(own)*SW +: SW];
      s_dat_w = m_dat_w[int'(own)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ack removes the stall, so a same-cycle ack always beats the timeout.
  always_comb begin
    stall = s_stb && !s_ack && !s_err;
    tmo   = (TIMEOUT != 0) && (timer_q == TW'(TMO_LAST)) && stall;
    m_ack = '0;
    m_err = '0;
    if (active) begin
      m_ack[own] = s_ack;
      m_err[own] = s_err || tmo;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (!active || state_d != state_q || s_ack || s_err || tmo)
      timer_d = '0;
    else if (stall && timer_q != '1)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  assign m_dat_r = s_dat_r;
  assign grant   = {state_q == ST_OWN1, state_q == ST_OWN0};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: expectations queued at stimulus time, popped at sampling.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr;
  logic [7:0]  m_sel;
  logic [63:0] m_dat_w;
  logic [31:0] m_dat_r;
  logic [1:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_w;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  wb_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.tag = "none";
      e.val = ~obs;
    end
    check_eq(tag, obs, e.val);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    m_cyc[n]            = cyc;
    m_stb[n]            = stb;
    m_we[n]             = we;
    m_adr[n*32 +: 32]   = adr;
    m_sel[n*4 +: 4]     = sel;
    m_dat_w[n*32 +: 32] = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] rr_exp;
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_dat_w = '0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_grant", 0); push("rst_scyc", 0); push("rst_ack", 0); push("rst_err", 0);
    @(negedge clk);
    pop_check("rst_grant", grant); pop_check("rst_scyc", s_cyc);
    pop_check("rst_ack", m_ack); pop_check("rst_err", m_err);
    rst = 1'b0;
    step();

    // Test 1: simultaneous request, master 0 first, handover without idle bubble
    drive_m(0, 1, 1, 0, 32'h0000_0100, 4'hf, 32'h0);
    drive_m(1, 1, 1, 0, 32'h8000_0000, 4'hf, 32'h0);
    push("t1_c0_grant", 2'b00);
    @(negedge clk);
    pop_check("t1_c0_grant", grant);
    step();
    s_ack = 1'b1;
    push("t1_c1_grant", 2'b01); push("t1_c1_adr", 32'h0000_0100); push("t1_c1_ack", 2'b01);
    @(negedge clk);
    pop_check("t1_c1_grant", grant); pop_check("t1_c1_adr", s_adr); pop_check("t1_c1_ack", m_ack);
    step();
    s_ack = 1'b0;
    m_stb[0] = 1'b0;
    step();
    step();
    m_cyc[0] = 1'b0;
    push("t1_c4_scyc", 0); push("t1_c4_grant", 2'b01);
    @(negedge clk);
    pop_check("t1_c4_scyc", s_cyc); pop_check("t1_c4_grant", grant);
    step();
    push("t1_c5_grant", 2'b10); push("t1_c5_adr", 32'h8000_0000); push("t1_c5_we", 0);
    @(negedge clk);
    pop_check("t1_c5_grant", grant); pop_check("t1_c5_adr", s_adr); pop_check("t1_c5_we", s_we);

    // Test 2: ibus read acked one cycle later
    step();
    s_ack = 1'b1;
    s_dat_r = 32'h1234_5678;
    push("t2_ack", 2'b10); push("t2_dat", 32'h1234_5678); push("t2_err", 2'b00);
    @(negedge clk);
    pop_check("t2_ack", m_ack); pop_check("t2_dat", m_dat_r); pop_check("t2_err", m_err);
    step();
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    step();
    push("t2_idle", 2'b00);
    @(negedge clk);
    pop_check("t2_idle", grant);

    // Test 3: hung slave, TIMEOUT=4; same-cycle ack beats the timeout at cycle 12
    drive_m(0, 1, 1, 0, 32'h0000_0200, 4'hf, 32'h0);
    step();
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) s_ack = 1'b1;
      push($sformatf("t3_err_c%0d", i), (i == 4 || i == 8) ? 2'b01 : 2'b00);
      if (i == 12) push("t3_ack_c12", 2'b01);
      @(negedge clk);
      pop_check($sformatf("t3_err_c%0d", i), m_err);
      if (i == 12) pop_check("t3_ack_c12", m_ack);
      step();
    end
    s_ack = 1'b0;
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Test 5: dbus write with ibus waiting; slave error pass-through
    drive_m(0, 1, 1, 1, 32'h0000_0040, 4'b0011, 32'hDEAD_BEEF);
    step();
    drive_m(1, 1, 1, 0, 32'h8000_0004, 4'hf, 32'h0);
    s_ack = 1'b1;
    push("t5_sel", 4'b0011); push("t5_dat", 32'hDEAD_BEEF); push("t5_we", 1);
    push("t5_ack", 2'b01); push("t5_grant", 2'b01);
    @(negedge clk);
    pop_check("t5_sel", s_sel); pop_check("t5_dat", s_dat_w); pop_check("t5_we", s_we);
    pop_check("t5_ack", m_ack); pop_check("t5_grant", grant);
    step();
    s_ack = 1'b0;
    s_err = 1'b1;
    push("t5_err", 2'b01); push("t5_err_ack", 2'b00);
    @(negedge clk);
    pop_check("t5_err", m_err); pop_check("t5_err_ack", m_ack);
    step();
    s_err = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
    step();
    push("t5_handover", 2'b10);
    @(negedge clk);
    pop_check("t5_handover", grant);
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Test 4: repeated simultaneous single transfers from IDLE
    for (int r = 0; r < 4; r++) begin
      drive_m(0, 1, 1, 0, 32'h0000_0300, 4'hf, 32'h0);
      drive_m(1, 1, 1, 0, 32'h8000_0300, 4'hf, 32'h0);
      step();
      s_ack = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      rr_exp = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
      rr_exp = 2'b01;
`endif
      push($sformatf("t4_grant_r%0d", r), rr_exp);
      @(negedge clk);
      pop_check($sformatf("t4_grant_r%0d", r), grant);
      step();
      s_ack = 1'b0;
      m_cyc = '0; m_stb = '0;
      step();
    end

    // Test 6: asynchronous reset mid-transfer
    drive_m(0, 1, 1, 0, 32'h0000_0400, 4'hf, 32'h0);
    step();
    push("t6_pre_grant", 2'b01); push("t6_pre_scyc", 1);
    @(negedge clk);
    pop_check("t6_pre_grant", grant); pop_check("t6_pre_scyc", s_cyc);
    #1 rst = 1'b1;
    #1;
    push("t6_rst_grant", 2'b00); push("t6_rst_scyc", 0);
    pop_check("t6_rst_grant", grant); pop_check("t6_rst_scyc", s_cyc);
    #1 rst = 1'b0;
    #1;
    push("t6_post_idle", 2'b00);
    pop_check("t6_post_idle", grant);
    step();
    push("t6_regrant", 2'b01);
    @(negedge clk);
    pop_check("t6_regrant", grant);
    m_cyc = '0; m_stb = '0;
    step();

    check_eq("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
